// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift-unit sequencer: unit ops, fill policies and FSM states.
package shift_seq_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        SH_LOAD  = 2'd0,
        SH_LEFT  = 2'd1,
        SH_RIGHT = 2'd2,
        SH_CLEAR = 2'd3
    } shOpT;

    typedef enum logic [1:0] {
        FILL_ZERO  = 2'd0,
        FILL_ONE   = 2'd1,
        FILL_CHAIN = 2'd2,
        FILL_SIGN  = 2'd3
    } fillT;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } stateT;

endpackage

// File: rtl/shift_seq.sv
// Multi-cycle sequencer that turns one load/shift/clear command into a series of
// single-step ops on the external shift unit, feeding the unit's output back in.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int AMT_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic [1:0]        cmdOp,
    input  logic [AMT_W-1:0]  cmdAmt,
    input  logic [1:0]        cmdFill,
    input  logic              cmdCarry,
    input  logic [DATA_W-1:0] cmdData,
    output logic [1:0]        shOp,
    output logic              shCarryIn,
    output logic [DATA_W-1:0] shLhsIn,
    input  logic [DATA_W-1:0] shLhsOut,
    input  logic              shCarryOut,
    output logic              resValid,
    output logic [DATA_W-1:0] resData,
    output logic              resCarry
);

    stateT             state;
    logic [1:0]        opQ;
    logic [1:0]        fillQ;
    logic [AMT_W-1:0]  amtQ;
    logic [AMT_W-1:0]  count;
    logic              carryQ;
    logic              first;
    logic [DATA_W-1:0] dataQ;

    // Control outputs are registered alongside the state so they change only at edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            opQ      <= '0;
            fillQ    <= '0;
            amtQ     <= '0;
            count    <= '0;
            carryQ   <= 1'b0;
            first    <= 1'b0;
            dataQ    <= '0;
            cmdReady <= 1'b1;
            resValid <= 1'b0;
            shOp     <= SH_LOAD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmdValid) begin
                        opQ      <= cmdOp;
                        amtQ     <= cmdAmt;
                        fillQ    <= cmdFill;
                        carryQ   <= cmdCarry;
                        dataQ    <= cmdData;
                        cmdReady <= 1'b0;
                        if (cmdOp == SH_CLEAR) begin
                            state <= ST_CLEAR;
                            shOp  <= SH_CLEAR;
                        end else begin
                            state <= ST_LOAD;
                            shOp  <= SH_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    count <= amtQ;
                    first <= 1'b1;
                    if (opQ == SH_LOAD || amtQ == '0) begin
                        state    <= ST_DONE;
                        shOp     <= SH_LOAD;
                        resValid <= 1'b1;
                    end else begin
                        state <= ST_SHIFT;
                        shOp  <= opQ;
                    end
                end
                ST_SHIFT: begin
                    count <= count - 1'b1;
                    first <= 1'b0;
                    if (count == AMT_W'(1)) begin
                        state    <= ST_DONE;
                        shOp     <= SH_LOAD;
                        resValid <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state    <= ST_DONE;
                    shOp     <= SH_LOAD;
                    resValid <= 1'b1;
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    resValid <= 1'b0;
                    cmdReady <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    resValid <= 1'b0;
                    cmdReady <= 1'b1;
                    shOp     <= SH_LOAD;
                end
            endcase
        end
    end

    // Outside LOAD the unit is re-loaded with its own output, which is how data is held.
    always_comb begin
        shLhsIn   = (state == ST_LOAD) ? dataQ : shLhsOut;
        shCarryIn = 1'b0;
        if (state == ST_SHIFT) begin
            case (fillQ)
                FILL_ZERO:  shCarryIn = 1'b0;
                FILL_ONE:   shCarryIn = 1'b1;
                FILL_CHAIN: shCarryIn = first ? carryQ : shCarryOut;
                default:    shCarryIn = (opQ == SH_RIGHT) ? shLhsOut[DATA_W-1] : shLhsOut[0];
            endcase
        end
    end

    assign resData  = shLhsOut;
    assign resCarry = shCarryOut;

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: a behavioural shift unit closes the loop, and results are
// compared against a reference computed directly from the shift/fill rules.
module tb_shift_seq;

    localparam int AMT_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmdValid = 1'b0;
    logic             cmdReady;
    logic [1:0]       cmdOp = '0;
    logic [AMT_W-1:0] cmdAmt = '0;
    logic [1:0]       cmdFill = '0;
    logic             cmdCarry = 1'b0;
    logic [7:0]       cmdData = '0;
    logic [1:0]       shOp;
    logic             shCarryIn;
    logic [7:0]       shLhsIn;
    logic [7:0]       shLhsOut = '0;
    logic             shCarryOut = 1'b0;
    logic             resValid;
    logic [7:0]       resData;
    logic             resCarry;

    int nCmp = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    shift_seq #(.AMT_W(AMT_W)) dut (
        .clk(clk), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdAmt(cmdAmt),
        .cmdFill(cmdFill), .cmdCarry(cmdCarry), .cmdData(cmdData),
        .shOp(shOp), .shCarryIn(shCarryIn), .shLhsIn(shLhsIn),
        .shLhsOut(shLhsOut), .shCarryOut(shCarryOut),
        .resValid(resValid), .resData(resData), .resCarry(resCarry)
    );

    // Single-step shift unit with one-cycle registered latency.
    always @(posedge clk) begin
        case (shOp)
            2'd0: begin shLhsOut <= shLhsIn; shCarryOut <= shCarryIn; end
            2'd1: {shCarryOut, shLhsOut} <= {shLhsIn, shCarryIn};
            2'd2: {shLhsOut, shCarryOut} <= {shCarryIn, shLhsIn};
            default: begin shLhsOut <= 8'h00; shCarryOut <= 1'b0; end
        endcase
    end

    // Returns {carry, data} after the whole command.
    function automatic logic [8:0] refResult(input logic [1:0] op, input int amt,
                                             input logic [1:0] fill, input logic cin0,
                                             input logic [7:0] d);
        logic [7:0] v;
        logic       c;
        logic       f;
        v = d;
        c = 1'b0;
        if (op == 2'd3) return 9'h000;
        if (op == 2'd0) return {1'b0, d};
        for (int i = 0; i < amt; i++) begin
            case (fill)
                2'd0:    f = 1'b0;
                2'd1:    f = 1'b1;
                2'd2:    f = (i == 0) ? cin0 : c;
                default: f = (op == 2'd2) ? v[7] : v[0];
            endcase
            if (op == 2'd1) begin
                c = v[7];
                v = {v[6:0], f};
            end else begin
                c = v[0];
                v = {f, v[7:1]};
            end
        end
        return {c, v};
    endfunction

    function automatic int refLatency(input logic [1:0] op, input int amt);
        if (op == 2'd0 || op == 2'd3 || amt == 0) return 2;
        return amt + 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input int amt, input logic [1:0] fill,
                         input logic cin, input logic [7:0] d, input bit hold);
        @(negedge clk);
        check("ready_before_issue", 32'(cmdReady), 32'd1);
        cmdOp    = op;
        cmdAmt   = AMT_W'(amt);
        cmdFill  = fill;
        cmdCarry = cin;
        cmdData  = d;
        cmdValid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) cmdValid = 1'b0;
    endtask

    // Counts cycles after the accept edge; optionally scrambles cmd* while busy.
    task automatic waitRes(input int expLat, input logic [7:0] expD, input logic expC,
                           input bit scramble, input string tag);
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (resValid === 1'b1) begin
                lat  = n;
                seen = 1;
                if (scramble) cmdValid = 1'b0;
                break;
            end
            check({tag, "_busy_ready"}, 32'(cmdReady), 32'd0);
            if (scramble) begin
                cmdOp    = 2'($urandom);
                cmdAmt   = AMT_W'($urandom);
                cmdFill  = 2'($urandom);
                cmdCarry = 1'($urandom);
                cmdData  = 8'($urandom);
                cmdValid = 1'($urandom);
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_latency"}, 32'(lat), 32'(expLat));
            check({tag, "_data"}, 32'(resData), 32'(expD));
            check({tag, "_carry"}, 32'(resCarry), 32'(expC));
            check({tag, "_done_ready"}, 32'(cmdReady), 32'd0);
            @(negedge clk);
            check({tag, "_pulse_end"}, 32'(resValid), 32'd0);
            check({tag, "_idle_ready"}, 32'(cmdReady), 32'd1);
        end
    endtask

    task automatic runCmd(input logic [1:0] op, input int amt, input logic [1:0] fill,
                          input logic cin, input logic [7:0] d, input bit scramble,
                          input string tag);
        logic [8:0] r;
        r = refResult(op, amt, fill, cin, d);
        issue(op, amt, fill, cin, d, 1'b0);
        waitRes(refLatency(op, amt), r[7:0], r[8], scramble, tag);
    endtask

    initial begin
        logic [8:0] ra;
        logic [8:0] rb;
        bit         sawPulse;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cmdReady), 32'd1);
        check("rst_resvalid", 32'(resValid), 32'd0);
        check("rst_shop", 32'(shOp), 32'd0);
        check("rst_carryin", 32'(shCarryIn), 32'd0);
        check("rst_lhs_hold", 32'(shLhsIn), 32'(shLhsOut));
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cmdReady), 32'd1);

        issue(2'd1, 3, 2'd0, 1'b0, 8'h81, 1'b0);
        waitRes(5, 8'h08, 1'b0, 1'b0, "lsl");
        issue(2'd2, 2, 2'd3, 1'b0, 8'h90, 1'b0);
        waitRes(4, 8'hE4, 1'b0, 1'b0, "asr");
        issue(2'd1, 1, 2'd2, 1'b1, 8'h80, 1'b0);
        waitRes(3, 8'h01, 1'b1, 1'b0, "chain1");
        issue(2'd1, 2, 2'd2, 1'b1, 8'h80, 1'b0);
        waitRes(4, 8'h03, 1'b0, 1'b0, "chain2");
        issue(2'd0, 5, 2'd1, 1'b1, 8'h5A, 1'b0);
        waitRes(2, 8'h5A, 1'b0, 1'b0, "load_only");
        issue(2'd2, 0, 2'd1, 1'b1, 8'h5A, 1'b0);
        waitRes(2, 8'h5A, 1'b0, 1'b0, "amt_zero");
        issue(2'd3, 6, 2'd1, 1'b1, 8'hFF, 1'b0);
        waitRes(2, 8'h00, 1'b0, 1'b0, "clear");
        runCmd(2'd2, 7, 2'd1, 1'b0, 8'h00, 1'b0, "ror_fill1_max");

        // Back-to-back: cmdValid held high, second command presented right after accept.
        ra = refResult(2'd1, 4, 2'd3, 1'b0, 8'hC3);
        rb = refResult(2'd2, 3, 2'd2, 1'b1, 8'h3C);
        issue(2'd1, 4, 2'd3, 1'b0, 8'hC3, 1'b1);
        cmdOp = 2'd2; cmdAmt = 3'd3; cmdFill = 2'd2; cmdCarry = 1'b1; cmdData = 8'h3C;
        waitRes(refLatency(2'd1, 4), ra[7:0], ra[8], 1'b0, "b2b_first");
        @(posedge clk);
        #1;
        cmdValid = 1'b0;
        waitRes(refLatency(2'd2, 3), rb[7:0], rb[8], 1'b0, "b2b_second");

        // Reset during a long shift must abort without a result pulse.
        issue(2'd1, 7, 2'd0, 1'b0, 8'hA5, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_ready", 32'(cmdReady), 32'd1);
        check("abort_resvalid", 32'(resValid), 32'd0);
        check("abort_shop", 32'(shOp), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sawPulse = 0;
        repeat (12) begin
            @(negedge clk);
            if (resValid === 1'b1) sawPulse = 1;
        end
        check("abort_no_pulse", 32'(sawPulse), 32'd0);
        runCmd(2'd2, 5, 2'd3, 1'b0, 8'hB7, 1'b0, "after_abort");

        for (int k = 0; k < 40; k++) begin
            runCmd(2'($urandom), int'($urandom_range(0, 7)), 2'($urandom), 1'($urandom),
                   8'($urandom), 1'b1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
